seven_segment_scanner: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_glyph.sv | 13 +
 rtl/seven_segment_scanner.sv | 185 ++++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment definitions.
//  seg7_t       segment pattern, bit order {g,f,e,d,c,b,a}
//  SEG7_OFF     active-low "all segments off"
//  GLYPH_TABLE  active-high hex glyphs 0..F
//  glyph()      nibble -> active-high pattern
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_OFF = 7'h7F;

  localparam seg7_t GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  function automatic seg7_t glyph(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// seg7_glyph: combinational hex nibble to active-high segment pattern.
//  nibble   in  4  hex digit
//  pattern  out 7  active-high {g,f,e,d,c,b,a}
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      pattern
);

  assign pattern = glyph(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed driver for NUM_DIGITS common-anode
// 7-segment digits on a shared segment bus. The packed value is snapshotted
// once per frame; each digit slot lasts REFRESH_DIV clocks, the first
// DEAD_CYCLES of which keep all anodes off to avoid ghosting. Supports
// per-digit decimal point and leading-zero blanking. All outputs registered.
// Optional: define SEG_SCAN_BLINK_EN to add blink_mask and BLINK_FRAMES.
//  clk         in   system clock
//  rst_n       in   asynchronous active-low reset
//  en          in   1 = scan, 0 = dark and held at digit 0
//  value       in   packed hex digits, digit i = value[4i+3:4i]
//  dp          in   decimal point request per digit
//  blank_lz    in   suppress leading zero digits
//  blink_mask  in   (SEG_SCAN_BLINK_EN) digits that blink
//  segments    out  active-low {g,f,e,d,c,b,a}
//  dp_out      out  active-low decimal point
//  anodes      out  active-low digit enables
//  frame_done  out  1-cycle pulse when scan wraps to digit 0
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 2
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output seg7_t                   segments,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] snap;
  logic [NUM_DIGITS-1:0]   dp_snap;

  logic tick, wrap;
  assign tick = en && (cnt == CNT_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // Leading-zero blanking: walk from the most significant digit down,
  // blanking while every digit seen so far (including this one) is zero.
  logic [NUM_DIGITS-1:0] blank_vec;
  always_comb begin
    logic run;
    run = 1'b1;
    blank_vec = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      int unsigned i;
      i = NUM_DIGITS - 1 - j;
      run = run && (snap[4*i +: 4] == 4'h0);
      blank_vec[i] = blank_lz && run && (i != 0);
    end
  end

  // Select the current digit's nibble, flags and anode pattern.
  logic [3:0]            cur_nibble;
  logic                  cur_blank, cur_dp;
  logic [NUM_DIGITS-1:0] sel_an;
  always_comb begin
    cur_nibble = 4'h0;
    cur_blank  = 1'b0;
    cur_dp     = 1'b0;
    sel_an     = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble = snap[4*i +: 4];
        cur_blank  = blank_vec[i];
        cur_dp     = dp_snap[i];
        sel_an[i]  = 1'b0;
      end
    end
  end

  seg7_t cur_glyph;
  seg7_glyph u_glyph (
    .nibble  (cur_nibble),
    .pattern (cur_glyph)
  );

  logic cur_hidden;
`ifdef SEG_SCAN_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic               cur_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!en) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (wrap) begin
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  always_comb begin
    cur_mask = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur_mask = blink_mask[i];
    end
  end

  assign cur_hidden = !blink_on && cur_mask;
`else
  assign cur_hidden = 1'b0;
`endif

  // Next output values; a blanked digit with its dp lit still enables its anode.
  seg7_t                 seg_n;
  logic                  dp_n;
  logic [NUM_DIGITS-1:0] an_n;
  always_comb begin
    seg_n = SEG7_OFF;
    dp_n  = 1'b1;
    an_n  = '1;
    if (en && !cur_hidden) begin
      if (!cur_blank) seg_n = ~cur_glyph;
      dp_n = ~cur_dp;
      if ((!cur_blank || cur_dp) && (cnt >= CNT_DEAD)) an_n = sel_an;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      snap       <= '0;
      dp_snap    <= '0;
      segments   <= SEG7_OFF;
      dp_out     <= 1'b1;
      anodes     <= '1;
      frame_done <= 1'b0;
    end else begin
      segments   <= seg_n;
      dp_out     <= dp_n;
      anodes     <= an_n;
      frame_done <= wrap;
      if (!en) begin
        cnt     <= '0;
        idx     <= '0;
        snap    <= value;
        dp_snap <= dp;
      end else begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        if (tick) begin
          if (idx == IDX_LAST) begin
            idx     <= '0;
            snap    <= value;
            dp_snap <= dp;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed self-checking bench for
// seven_segment_scanner with NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [6:0]  segments;
  logic        dp_out;
  logic [3:0]  anodes;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .DEAD_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .value      (value),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .segments   (segments),
    .dp_out     (dp_out),
    .anodes     (anodes),
    .frame_done (frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold scan off for two cycles so the snapshot takes the current inputs,
  // then enable; the next step shows digit 0 in its dead cycle.
  task automatic begin_frame();
    en = 1'b0;
    step();
    step();
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    value = 16'h12AF;
    dp = 4'hF;
    blank_lz = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (segments !== 7'h7F || anodes !== 4'hF || dp_out !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: seg=%h an=%h dp=%b fd=%b want seg=7f an=f dp=1 fd=0",
                 k, segments, anodes, dp_out, frame_done);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [6:0] segt [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    logic [3:0] ant  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [3:0] exp_an;
    logic       exp_fd;
    value = 16'h12AF;
    dp = 4'h0;
    blank_lz = 1'b0;
    begin_frame();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp_an = (c == 0) ? 4'hF : ant[s];
        exp_fd = (s == 3 && c == 3);
        checks++;
        if (segments !== segt[s]) begin
          errors++;
          $display("FAIL scan_seg s%0d c%0d: got %h want %h", s, c, segments, segt[s]);
        end
        checks++;
        if (anodes !== exp_an) begin
          errors++;
          $display("FAIL scan_an s%0d c%0d: got %h want %h", s, c, anodes, exp_an);
        end
        checks++;
        if (frame_done !== exp_fd || dp_out !== 1'b1) begin
          errors++;
          $display("FAIL scan_fd_dp s%0d c%0d: fd=%b dp=%b want fd=%b dp=1", s, c, frame_done, dp_out, exp_fd);
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      step();
      exp_fd = (k == 15);
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL frame_period k%0d: fd=%b want %b", k, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [6:0] segt [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    logic [3:0] ant  [4] = '{4'hE, 4'hD, 4'hF, 4'hF};
    logic [6:0] segz [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    logic [3:0] anz  [4] = '{4'hE, 4'hF, 4'hF, 4'hF};
    logic [3:0] exp_an;
    value = 16'h0050;
    dp = 4'h0;
    blank_lz = 1'b1;
    begin_frame();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp_an = (c == 0) ? 4'hF : ant[s];
        checks++;
        if (segments !== segt[s] || anodes !== exp_an || dp_out !== 1'b1) begin
          errors++;
          $display("FAIL blank_0050 s%0d c%0d: seg=%h an=%h dp=%b want seg=%h an=%h dp=1",
                   s, c, segments, anodes, dp_out, segt[s], exp_an);
        end
      end
    end
    value = 16'h0000;
    begin_frame();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp_an = (c == 0) ? 4'hF : anz[s];
        checks++;
        if (segments !== segz[s] || anodes !== exp_an) begin
          errors++;
          $display("FAIL blank_zero s%0d c%0d: seg=%h an=%h want seg=%h an=%h",
                   s, c, segments, anodes, segz[s], exp_an);
        end
      end
    end
  endtask

  task automatic test_dp_blank();
    logic [6:0] segt [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    logic [3:0] ant  [4] = '{4'hE, 4'hD, 4'hB, 4'hF};
    logic       dpt  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_an;
    value = 16'h0050;
    dp = 4'b0100;
    blank_lz = 1'b1;
    begin_frame();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp_an = (c == 0) ? 4'hF : ant[s];
        checks++;
        if (segments !== segt[s] || anodes !== exp_an || dp_out !== dpt[s]) begin
          errors++;
          $display("FAIL dp_blank s%0d c%0d: seg=%h an=%h dp=%b want seg=%h an=%h dp=%b",
                   s, c, segments, anodes, dp_out, segt[s], exp_an, dpt[s]);
        end
      end
    end
  endtask

  task automatic test_midframe();
    value = 16'h1111;
    dp = 4'h0;
    blank_lz = 1'b0;
    begin_frame();
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 1) begin
        value = 16'h2222;
        dp = 4'hF;
      end
      checks++;
      if (segments !== 7'h79 || dp_out !== 1'b1) begin
        errors++;
        $display("FAIL midframe k%0d: seg=%h dp=%b want seg=79 dp=1", k, segments, dp_out);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (segments !== 7'h24 || dp_out !== 1'b0) begin
        errors++;
        $display("FAIL next_frame k%0d: seg=%h dp=%b want seg=24 dp=0", k, segments, dp_out);
      end
    end
  endtask

  task automatic test_en_drop();
    value = 16'h12AF;
    dp = 4'h0;
    blank_lz = 1'b0;
    begin_frame();
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (anodes !== 4'hD || segments !== 7'h08) begin
      errors++;
      $display("FAIL en_pre: seg=%h an=%h want seg=08 an=d", segments, anodes);
    end
    en = 1'b0;
    step();
    checks++;
    if (segments !== 7'h7F || anodes !== 4'hF || dp_out !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL en_drop: seg=%h an=%h dp=%b fd=%b want 7f f 1 0", segments, anodes, dp_out, frame_done);
    end
    en = 1'b1;
    step();
    checks++;
    if (segments !== 7'h0E || anodes !== 4'hF) begin
      errors++;
      $display("FAIL en_restart_dead: seg=%h an=%h want seg=0e an=f", segments, anodes);
    end
    step();
    checks++;
    if (segments !== 7'h0E || anodes !== 4'hE) begin
      errors++;
      $display("FAIL en_restart: seg=%h an=%h want seg=0e an=e", segments, anodes);
    end
  endtask

  task automatic test_reset_mid();
    value = 16'h12AF;
    dp = 4'h0;
    blank_lz = 1'b0;
    begin_frame();
    for (int k = 0; k < 6; k++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (segments !== 7'h7F || anodes !== 4'hF || dp_out !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: seg=%h an=%h dp=%b fd=%b want 7f f 1 0", segments, anodes, dp_out, frame_done);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (segments !== 7'h40 || anodes !== 4'hF) begin
      errors++;
      $display("FAIL reset_restart_dead: seg=%h an=%h want seg=40 an=f", segments, anodes);
    end
    step();
    checks++;
    if (segments !== 7'h40 || anodes !== 4'hE) begin
      errors++;
      $display("FAIL reset_restart: seg=%h an=%h want seg=40 an=e", segments, anodes);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en = 1'b0;
    value = '0;
    dp = '0;
    blank_lz = 1'b0;
    #1;
    test_reset();
    test_scan();
    test_blank_lz();
    test_dp_blank();
    test_midframe();
    test_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
